// File: rtl/seq_train_scheduler.sv
// Purpose : gamma-synchronous training sequencer; walks a small table of
//           (input current, dwell) entries for N training rounds with
//           plasticity on, then optionally one frozen probe pass that scores
//           predictor error against ERR_TOL.
// Latency : stimulus changes on the clk carrying cycle_start; the first
//           stimulus appears 1..CYCLE_LEN clks after start.
// Backpressure: none; start/cfg_we are dropped while busy, abort always wins.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cycle_start           gamma cycle boundary pulse
//   cfg_we/addr/cur/dwell table write port (IDLE only)
//   n_pat_m1, n_rounds,   run configuration, sampled on start
//   probe_en
//   start, abort          run control
//   error_out/valid       predictor error stream, scored during probe
//   cur_out, learn_en,    stimulus and plasticity enable to the neuron chain
//   pat_idx
//   busy, done            status; done is a one-clk completion pulse
//   hit_cnt, sample_cnt   probe score, held until the next start
module seq_train_scheduler #(
    parameter int          N_PAT   = 4,
    parameter logic [7:0]  ERR_TOL = 8'd8,
    parameter int          CNT_W   = 16,
    localparam int         IDX_W   = $clog2(N_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cycle_start,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [7:0]       cfg_cur,
    input  logic [7:0]       cfg_dwell,
    input  logic [IDX_W-1:0] n_pat_m1,
    input  logic [7:0]       n_rounds,
    input  logic             probe_en,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       error_out,
    input  logic             error_valid,
    output logic [7:0]       cur_out,
    output logic             learn_en,
    output logic [IDX_W-1:0] pat_idx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] sample_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRAIN,
        S_PROBE,
        S_FIN
    } state_t;

    state_t state_q, state_d;

    // Pattern table
    logic [7:0] cur_tab   [N_PAT];
    logic [7:0] dwell_tab [N_PAT];

    // Run configuration latched at start
    logic [IDX_W-1:0] n_pat_m1_q;
    logic [7:0]       n_rounds_q;
    logic             probe_en_q;

    // Walk state
    logic [7:0] dwell_cnt;
    logic [7:0] round_cnt;

    // Control strobes from the next-state logic
    logic             latch_cfg;
    logic             load_en;
    logic [IDX_W-1:0] load_idx;
    logic             dec_en;
    logic             round_clr;
    logic             round_inc;
    logic             clr_out;

    logic       dwell_last;
    logic       pat_last;
    logic       round_more;
    logic [7:0] load_dwell;
    logic       count_en;

    assign dwell_last = (dwell_cnt == 8'd1);
    assign pat_last   = (pat_idx == n_pat_m1_q);
    // Compare in 9 bits so round_cnt+1 cannot wrap at 255.
    assign round_more = (({1'b0, round_cnt} + 9'd1) < {1'b0, n_rounds_q});
    // A zero dwell still occupies one gamma cycle.
    assign load_dwell = (dwell_tab[load_idx] == 8'd0) ? 8'd1 : dwell_tab[load_idx];

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign learn_en = (state_q == S_TRAIN);
    assign count_en = (state_q == S_PROBE) && error_valid && !abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        latch_cfg = 1'b0;
        load_en   = 1'b0;
        load_idx  = '0;
        dec_en    = 1'b0;
        round_clr = 1'b0;
        round_inc = 1'b0;
        clr_out   = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            clr_out = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_ARM;
                        latch_cfg = 1'b1;
                    end
                end

                S_ARM: begin
                    if (cycle_start) begin
                        if (n_rounds_q != 8'd0) begin
                            state_d   = S_TRAIN;
                            load_en   = 1'b1;
                            round_clr = 1'b1;
                        end else if (probe_en_q) begin
                            state_d = S_PROBE;
                            load_en = 1'b1;
                        end else begin
                            state_d = S_FIN;
                            clr_out = 1'b1;
                        end
                    end
                end

                S_TRAIN: begin
                    if (cycle_start) begin
                        if (!dwell_last) begin
                            dec_en = 1'b1;
                        end else if (!pat_last) begin
                            load_en  = 1'b1;
                            load_idx = pat_idx + IDX_W'(1);
                        end else if (round_more) begin
                            load_en   = 1'b1;
                            round_inc = 1'b1;
                        end else if (probe_en_q) begin
                            state_d = S_PROBE;
                            load_en = 1'b1;
                        end else begin
                            state_d = S_FIN;
                            clr_out = 1'b1;
                        end
                    end
                end

                S_PROBE: begin
                    if (cycle_start) begin
                        if (!dwell_last) begin
                            dec_en = 1'b1;
                        end else if (!pat_last) begin
                            load_en  = 1'b1;
                            load_idx = pat_idx + IDX_W'(1);
                        end else begin
                            state_d = S_FIN;
                            clr_out = 1'b1;
                        end
                    end
                end

                S_FIN: begin
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                    clr_out = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pattern table; writable only while idle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PAT; i++) begin
                cur_tab[i]   <= 8'd0;
                dwell_tab[i] <= 8'd1;
            end
        end else if (cfg_we && (state_q == S_IDLE) && !abort) begin
            cur_tab[cfg_addr]   <= cfg_cur;
            dwell_tab[cfg_addr] <= cfg_dwell;
        end
    end

    // ------------------------------------------------------------------
    // Run configuration and pattern walk
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_pat_m1_q <= '0;
            n_rounds_q <= 8'd0;
            probe_en_q <= 1'b0;
            pat_idx    <= '0;
            dwell_cnt  <= 8'd1;
            round_cnt  <= 8'd0;
            cur_out    <= 8'd0;
        end else begin
            if (latch_cfg) begin
                n_pat_m1_q <= n_pat_m1;
                n_rounds_q <= n_rounds;
                probe_en_q <= probe_en;
            end

            if (round_clr) begin
                round_cnt <= 8'd0;
            end else if (round_inc) begin
                round_cnt <= round_cnt + 8'd1;
            end

            if (load_en) begin
                pat_idx   <= load_idx;
                dwell_cnt <= load_dwell;
                cur_out   <= cur_tab[load_idx];
            end else if (dec_en) begin
                dwell_cnt <= dwell_cnt - 8'd1;
            end

            // Parking pat_idx at 0 keeps it within any later, smaller n_pat_m1.
            if (clr_out) begin
                cur_out <= 8'd0;
                pat_idx <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Probe scoring: saturating counters, cleared on start, held otherwise
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt    <= '0;
            sample_cnt <= '0;
        end else if (latch_cfg) begin
            hit_cnt    <= '0;
            sample_cnt <= '0;
        end else if (count_en) begin
            if (sample_cnt != {CNT_W{1'b1}}) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
            if ((error_out <= ERR_TOL) && (hit_cnt != {CNT_W{1'b1}})) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end
        end
    end

endmodule
